// File: rtl/cronometro_contador.sv
// rtl/cronometro_contador.sv - stopwatch core: 00..59 BCD seconds, start/stop/clear FSM, display scan selects (optional lap freeze under LAP_EN)
module cronometro_contador #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter int MAX_TENS = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_stop,
    input  logic clr,
    input  logic lap,
    output logic q10,
    output logic q11,
    output logic q12,
    output logic q13,
    output logic q21,
    output logic q22,
    output logic q23,
    output logic q24,
    output logic c1,
    output logic c2,
    output logic ovf,
    output logic running
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    TENS_LAST = 4'(MAX_TENS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [2:0]    ss_sync;
    logic [2:0]    clr_sync;
    logic          ss_edge;
    logic          clr_edge;
    logic [PW-1:0] presc;
    logic [3:0]    units;
    logic [3:0]    tens;
    logic [SW-1:0] scan_cnt;
    logic [3:0]    disp_units;
    logic [3:0]    disp_tens;

    // Two-stage synchronizers plus one history bit for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync  <= '0;
            clr_sync <= '0;
        end else begin
            ss_sync  <= {ss_sync[1:0], start_stop};
            clr_sync <= {clr_sync[1:0], clr};
        end
    end

    assign ss_edge  = ss_sync[1] & ~ss_sync[2];
    assign clr_edge = clr_sync[1] & ~clr_sync[2];

    // FSM state register; running is registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            running <= (state_d == RUN);
        end
    end

    // Next-state logic; clear wins over start/stop in the same cycle
    always_comb begin
        state_d = state_q;
        if (clr_edge) begin
            state_d = IDLE;
        end else if (ss_edge) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Prescaler and BCD seconds; prescaler only moves in RUN, so PAUSE keeps the remainder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            units <= 4'd0;
            tens  <= 4'd0;
            ovf   <= 1'b0;
        end else if (clr_edge) begin
            presc <= '0;
            units <= 4'd0;
            tens  <= 4'd0;
            ovf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (state_q == RUN) begin
                if (presc == PRE_LAST) begin
                    presc <= '0;
                    if (units == 4'd9) begin
                        units <= 4'd0;
                        if (tens >= TENS_LAST) begin
                            tens <= 4'd0;
                            ovf  <= 1'b1;
                        end else begin
                            tens <= tens + 4'd1;
                        end
                    end else begin
                        units <= units + 4'd1;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    // Display scan: enable rises once after reset, digit select free-runs regardless of clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1       <= 1'b0;
            c2       <= 1'b0;
            scan_cnt <= '0;
        end else begin
            c1 <= 1'b1;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                c2       <= ~c2;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

`ifdef LAP_EN
    logic [2:0] lap_sync;
    logic       lap_edge;
    logic       freeze;
    logic [3:0] snap_units;
    logic [3:0] snap_tens;

    assign lap_edge = lap_sync[1] & ~lap_sync[2];

    // Lap freeze: toggled by lap edges in RUN, snapshot taken from the live count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_sync   <= '0;
            freeze     <= 1'b0;
            snap_units <= 4'd0;
            snap_tens  <= 4'd0;
        end else begin
            lap_sync <= {lap_sync[1:0], lap};
            if (clr_edge) begin
                freeze <= 1'b0;
            end else if (lap_edge && (state_q == RUN)) begin
                freeze <= ~freeze;
                if (!freeze) begin
                    snap_units <= units;
                    snap_tens  <= tens;
                end
            end
        end
    end

    assign disp_units = freeze ? snap_units : units;
    assign disp_tens  = freeze ? snap_tens  : tens;
`else
    logic lap_unused;
    assign lap_unused = lap;
    assign disp_units = units;
    assign disp_tens  = tens;
`endif

    assign {q13, q12, q11, q10} = disp_units;
    assign {q24, q23, q22, q21} = disp_tens;

endmodule
